// File: rtl/spi_req_arbiter_pkg.sv
// Shared types and the round-robin search used by the SPI request arbiter.
package spi_pkg;

  // Arbiter control states, in transfer order.
  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_EN,
    XFER,
    RESP
  } arb_state_t;

  // Byte width of the SPI_driver transfer engine.
  localparam int SPI_DATA_W = 8;

  // Widest request vector the search function handles.
  localparam int RR_MAX_REQ = 8;

  typedef struct packed {
    logic found;
    int   idx;
  } rr_pick_t;

  // First set bit of req[n-1:0], searching upward from ptr with wrap-around.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                       input int ptr, input int n);
    rr_pick_t res;
    int       j;
    res.found = 1'b0;
    res.idx   = 0;
    for (int k = 0; k < RR_MAX_REQ; k++) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (!res.found && req[j[2:0]]) begin
          res.found = 1'b1;
          res.idx   = j;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: rotates the request vector to start at
// ptr and priority-encodes the first pending requester.
module spi_rr_picker
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [RR_MAX_REQ-1:0] req_ext;
  rr_pick_t              pick;

  // Widen to the search function's fixed width and encode the winner.
  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    pick                 = rr_pick(req_ext, int'(ptr), NUM_REQ);
    found                = pick.found;
    idx                  = IDX_W'(pick.idx);
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI_driver byte engine between NUM_REQ
// requesters. Completion is taken from the driver's spi_en falling; a
// watchdog aborts transfers that never start or never finish.
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = SPI_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      spi_start,
  output logic [DATA_W-1:0]         spi_data_in,
  input  logic                      spi_en,
  input  logic [DATA_W-1:0]         spi_data_out,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  spi_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state, latch and watchdog logic for the transfer sequence.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    err_d    = err_q;
    wd_d     = wd_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          tx_d    = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          state_d = START;
        end
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT_EN;
      end
      WAIT_EN: begin
        // A transfer that never starts is aborted before spi_en is honoured.
        if (wd_q == WD_LAST) begin
          rx_d    = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
          if (spi_en) state_d = XFER;
        end
      end
      XFER: begin
        // Completion wins over a timeout in the same cycle: the byte is valid.
        if (!spi_en) begin
          rx_d    = spi_data_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          rx_d    = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        rr_ptr_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        err_d    = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

  // Grant and response strobes decoded from registered state only.
  always_comb begin
    grant     = '0;
    rsp_valid = '0;
    if (state_q != IDLE) grant[idx_q] = 1'b1;
    if (state_q == RESP) rsp_valid[idx_q] = 1'b1;
  end

  assign spi_start   = (state_q == START);
  assign spi_data_in = tx_q;
  assign rsp_data    = rx_q;
  assign rsp_err     = err_q;
  assign busy        = (state_q != IDLE);

endmodule
